// File: rtl/wb_sram_b3.sv
// ---------------------------------------------------------------------------
// wb_sram_b3 -- Wishbone B3 single-port SRAM slave, 32-bit data, byte selects.
//
// Depth is 2**MEM_ADDR_W words; the word index is wb_adr_i[MEM_ADDR_W+1:2].
// The remaining address bits are ignored.
//
// Cycle types:
//   classic (000, 001 and 111) : single access, acknowledged one cycle after the request.
//   incrementing burst (010)   : linear or wrap-4/8/16 according to wb_bte_i.
//                                Beats after the first have zero wait states.
//   reserved (011..110)        : a one-cycle wb_err_o, with no memory access.
//
// Build option:
//   WB_SRAM_BURST_EN defined   : the BURST state and the internal burst pointer
//                                are built.
//   WB_SRAM_BURST_EN undefined : cti 010 takes the classic path, so every beat
//                                costs two cycles. The master's per-beat
//                                addresses keep the burst correct.
//
// Ports:
//   wb_clk_i           clock; all state changes on the rising edge
//   wb_rst_i           synchronous active-high reset; memory contents are kept
//   wb_adr_i/dat_i     byte address / write data
//   wb_sel_i           byte-lane enables for writes
//   wb_we_i            1 = write, 0 = read
//   wb_cyc_i/stb_i     bus cycle / strobe
//   wb_cti_i/bte_i     cycle type / burst type extension
//   wb_dat_o           read data, valid while wb_ack_o is high
//   wb_ack_o/err_o     beat acknowledge / error termination (never both high)
//   wb_rty_o           tied low
// ---------------------------------------------------------------------------
module wb_sram_b3 #(
   parameter int MEM_ADDR_W = 10
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_we_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic [2:0]  wb_cti_i,
   input  logic [1:0]  wb_bte_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic        wb_err_o,
   output logic        wb_rty_o
);

   localparam int DEPTH = 1 << MEM_ADDR_W;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACK   = 2'd1,
      ST_ERR   = 2'd2
`ifdef WB_SRAM_BURST_EN
      , ST_BURST = 2'd3
`endif
   } state_e;

`ifdef WB_SRAM_BURST_EN
   // Next burst word index. A mask of all ones gives the linear case.
   // Otherwise the low bits wrap inside the aligned 4/8/16-word block.
   function automatic logic [MEM_ADDR_W-1:0] next_ptr(input logic [MEM_ADDR_W-1:0] p,
                                                      input logic [1:0]            bte);
      logic [MEM_ADDR_W-1:0] mask;
      logic [MEM_ADDR_W-1:0] inc;
      inc = p + {{(MEM_ADDR_W-1){1'b0}}, 1'b1};
      case (bte)
         2'b00:   mask = {MEM_ADDR_W{1'b1}};
         2'b01:   mask = {{(MEM_ADDR_W-2){1'b0}}, 2'b11};
         2'b10:   mask = {{(MEM_ADDR_W-3){1'b0}}, 3'b111};
         2'b11:   mask = {{(MEM_ADDR_W-4){1'b0}}, 4'b1111};
         default: mask = {MEM_ADDR_W{1'b1}};
      endcase
      return (p & ~mask) | (inc & mask);
   endfunction
`endif

   logic [31:0]           mem [DEPTH];

   state_e                state_q, state_d;
   logic                  ack_q, ack_d;
   logic                  err_q, err_d;
   logic [31:0]           dat_q, dat_d;
`ifdef WB_SRAM_BURST_EN
   logic [MEM_ADDR_W-1:0] ptr_q, ptr_d;
`endif

   logic                  req_s;
   logic                  cti_reserved_s;
   logic [MEM_ADDR_W-1:0] adr_idx_s;
   logic                  mem_we_s;
   logic [MEM_ADDR_W-1:0] mem_wadr_s;
   logic                  burst_ack_s;
   logic                  unused_bits_s;

   assign req_s          = wb_cyc_i & wb_stb_i;
   assign cti_reserved_s = (wb_cti_i >= 3'b011) && (wb_cti_i <= 3'b110);
   assign adr_idx_s      = wb_adr_i[MEM_ADDR_W+1:2];
   assign unused_bits_s  = ^{wb_adr_i[31:MEM_ADDR_W+2], wb_adr_i[1:0], wb_bte_i};

   // Next-state, output and memory-port decode.
   always_comb begin
      state_d     = state_q;
      ack_d       = 1'b0;
      err_d       = 1'b0;
      dat_d       = dat_q;
`ifdef WB_SRAM_BURST_EN
      ptr_d       = ptr_q;
`endif
      mem_we_s    = 1'b0;
      mem_wadr_s  = adr_idx_s;
      burst_ack_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!req_s) begin
               state_d = ST_IDLE;
            end else if (cti_reserved_s) begin
               state_d = ST_ERR;
               err_d   = 1'b1;
            end
`ifdef WB_SRAM_BURST_EN
            else if (wb_cti_i == 3'b010) begin
               // Only the first beat's address is used. Prefetch it; no write this cycle.
               state_d = ST_BURST;
               ptr_d   = adr_idx_s;
               dat_d   = mem[adr_idx_s];
            end
`endif
            else begin
               state_d = ST_ACK;
               ack_d   = 1'b1;
               if (wb_we_i) begin
                  mem_we_s = 1'b1;
               end else begin
                  dat_d = mem[adr_idx_s];
               end
            end
         end
         ST_ACK: begin
            state_d = ST_IDLE;
         end
         ST_ERR: begin
            state_d = ST_IDLE;
         end
`ifdef WB_SRAM_BURST_EN
         ST_BURST: begin
            if (!wb_cyc_i) begin
               state_d = ST_IDLE;
            end else if (wb_stb_i) begin
               // Acked beat: write at ptr, then prefetch next(ptr) for a zero-wait next beat.
               burst_ack_s = 1'b1;
               ptr_d       = next_ptr(ptr_q, wb_bte_i);
               dat_d       = mem[ptr_d];
               if (wb_we_i) begin
                  mem_we_s   = 1'b1;
                  mem_wadr_s = ptr_q;
               end else begin
                  mem_we_s   = 1'b0;
               end
               if (wb_cti_i == 3'b111) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_BURST;
               end
            end else begin
               burst_ack_s = 1'b0;
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Control and output registers, with synchronous reset.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= ST_IDLE;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         dat_q   <= 32'h0000_0000;
`ifdef WB_SRAM_BURST_EN
         ptr_q   <= {MEM_ADDR_W{1'b0}};
`endif
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         dat_q   <= dat_d;
`ifdef WB_SRAM_BURST_EN
         ptr_q   <= ptr_d;
`endif
      end
   end

   // Byte-lane write port. Memory is not cleared by reset, and reset blocks any write.
   always_ff @(posedge wb_clk_i) begin
      if (mem_we_s && !wb_rst_i) begin
         for (int b = 0; b < 4; b++) begin
            if (wb_sel_i[b]) begin
               mem[mem_wadr_s][8*b +: 8] <= wb_dat_i[8*b +: 8];
            end
         end
      end
   end

   assign wb_ack_o = ack_q | burst_ack_s;
   assign wb_err_o = err_q;
   assign wb_dat_o = dat_q;
   assign wb_rty_o = 1'b0;

endmodule

// File: tb/tb_wb_sram_b3.sv
// Self-checking bench for wb_sram_b3. A word-array model of the SRAM predicts
// every read. Burst addresses come from modular arithmetic on the wrap block.
module tb_wb_sram_b3;

   localparam int AW    = 10;
   localparam int DEPTH = 1 << AW;
`ifdef WB_SRAM_BURST_EN
   localparam bit BURST_HW = 1'b1;
`else
   localparam bit BURST_HW = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        wb_rst_i;
   logic [31:0] wb_adr_i;
   logic [31:0] wb_dat_i;
   logic [3:0]  wb_sel_i;
   logic        wb_we_i;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic [2:0]  wb_cti_i;
   logic [1:0]  wb_bte_i;
   logic [31:0] wb_dat_o;
   logic        wb_ack_o;
   logic        wb_err_o;
   logic        wb_rty_o;

   always #5 clk = ~clk;

   wb_sram_b3 #(.MEM_ADDR_W(AW)) dut (
      .wb_clk_i (clk),
      .wb_rst_i (wb_rst_i),
      .wb_adr_i (wb_adr_i),
      .wb_dat_i (wb_dat_i),
      .wb_sel_i (wb_sel_i),
      .wb_we_i  (wb_we_i),
      .wb_cyc_i (wb_cyc_i),
      .wb_stb_i (wb_stb_i),
      .wb_cti_i (wb_cti_i),
      .wb_bte_i (wb_bte_i),
      .wb_dat_o (wb_dat_o),
      .wb_ack_o (wb_ack_o),
      .wb_err_o (wb_err_o),
      .wb_rty_o (wb_rty_o)
   );

   logic [31:0] model_mem [DEPTH];
   int          checks   = 0;
   int          failures = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Burst address sequence: linear modulo depth, or wrap inside an aligned N-word block
   function automatic int model_next(input int p, input logic [1:0] bte);
      int n;
      case (bte)
         2'b01:   n = 4;
         2'b10:   n = 8;
         2'b11:   n = 16;
         default: n = DEPTH;
      endcase
      if (bte == 2'b00) return (p + 1) % DEPTH;
      return (p - (p % n)) + (((p % n) + 1) % n);
   endfunction

   function automatic void model_write(input int idx, input logic [31:0] d, input logic [3:0] sel);
      for (int b = 0; b < 4; b++) begin
         if (sel[b]) model_mem[idx][8*b +: 8] = d[8*b +: 8];
      end
   endfunction

   task automatic bus_idle(input int n);
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_we_i  = 1'b0;
      wb_cti_i = 3'b000;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One beat: drive the request and wait (bounded) for ack or err. The ignored
   // address bits are filled with random junk. Returns at posedge+1 after termination.
   task automatic beat(input logic we, input int idx, input logic [31:0] d, input logic [3:0] sel,
                       input logic [2:0] cti, input logic [1:0] bte,
                       output logic [31:0] rdat, output int waits, output logic got_ack,
                       output logic got_err);
      logic [31:0] junk;
      junk     = $urandom;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      wb_we_i  = we;
      wb_adr_i = {junk[31:AW+2], idx[AW-1:0], junk[1:0]};
      wb_dat_i = d;
      wb_sel_i = sel;
      wb_cti_i = cti;
      wb_bte_i = bte;
      waits    = 0;
      got_ack  = 1'b0;
      got_err  = 1'b0;
      rdat     = 32'h0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (wb_ack_o || wb_err_o) begin
            got_ack = wb_ack_o;
            got_err = wb_err_o;
            rdat    = wb_dat_o;
            break;
         end
         waits++;
      end
      check_eq("ack_err_excl", 32'(got_ack & got_err), 32'd0);
      check_eq("rty_low", 32'(wb_rty_o), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic classic_write(input int idx, input logic [31:0] d, input logic [3:0] sel,
                                input logic [2:0] cti);
      logic [31:0] r;
      int          w;
      logic        a, e;
      beat(1'b1, idx, d, sel, cti, 2'($urandom), r, w, a, e);
      check_eq("cw_ack", 32'(a), 32'd1);
      check_eq("cw_lat", w, 32'd1);
      model_write(idx, d, sel);
      bus_idle(1);
   endtask

   task automatic classic_read(input int idx, input logic [2:0] cti, output logic [31:0] r);
      int   w;
      logic a, e;
      beat(1'b0, idx, $urandom, 4'($urandom), cti, 2'($urandom), r, w, a, e);
      check_eq("cr_ack", 32'(a), 32'd1);
      check_eq("cr_lat", w, 32'd1);
      check_eq("cr_data", r, model_mem[idx]);
      bus_idle(1);
   endtask

   // Burst of n beats (n >= 2). Each beat after index stall_after is followed by one stb-low cycle.
   task automatic burst(input logic we, input int start, input int n, input logic [1:0] bte,
                        input bit rand_data, input bit rand_sel, input logic [31:0] base_val,
                        input int stall_after, input string tag);
      int          cur, tot_w, w;
      logic [31:0] d, r;
      logic [3:0]  sel;
      logic [2:0]  cti;
      logic        a, e;
      cur   = start;
      tot_w = 0;
      for (int k = 0; k < n; k++) begin
         d   = rand_data ? $urandom : base_val + 32'(k);
         sel = rand_sel ? 4'($urandom) : 4'hF;
         cti = (k == n - 1) ? 3'b111 : 3'b010;
         beat(we, cur, d, sel, cti, bte, r, w, a, e);
         check_eq({tag, "_ack"}, 32'(a), 32'd1);
         if (we) model_write(cur, d, sel);
         else    check_eq({tag, "_rd"}, r, model_mem[cur]);
         tot_w += w;
         if (k == stall_after) begin
            wb_stb_i = 1'b0;
            @(negedge clk);
            check_eq({tag, "_stall_ack"}, 32'(wb_ack_o), 32'd0);
            @(posedge clk);
            #1;
         end
         cur = model_next(cur, bte);
      end
      bus_idle(1);
      check_eq({tag, "_lat"}, tot_w, BURST_HW ? 32'd1 : 32'(n));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r;
      int          w;
      logic        a, e;

      wb_rst_i = 1'b1;
      wb_adr_i = 32'h0;
      wb_dat_i = 32'h0;
      wb_sel_i = 4'h0;
      wb_we_i  = 1'b0;
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_cti_i = 3'b000;
      wb_bte_i = 2'b00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_ack", 32'(wb_ack_o), 32'd0);
      check_eq("rst_err", 32'(wb_err_o), 32'd0);
      check_eq("rst_dat", wb_dat_o, 32'h0);
      check_eq("rst_rty", 32'(wb_rty_o), 32'd0);
      @(posedge clk);
      #1;
      wb_rst_i = 1'b0;
      bus_idle(1);

      // Fill the whole memory so the model knows every word
      burst(1'b1, 0, DEPTH, 2'b00, 1'b1, 1'b0, 32'h0, -1, "init");

      // Classic write / read of 0xDEADBEEF at 0x10
      classic_write(4, 32'hDEADBEEF, 4'hF, 3'b000);
      classic_read(4, 3'b000, r);
      check_eq("t1_const", r, 32'hDEADBEEF);

      // Byte-select write of lane 0 only
      classic_write(4, 32'h000000AA, 4'b0001, 3'b000);
      classic_read(4, 3'b111, r);
      check_eq("t2_const", r, 32'hDEADBEAA);

      // Wrap-4 read from 0x18: words 0x18, 0x1C, 0x10, 0x14
      classic_write(7, 32'h1C1C_1C1C, 4'hF, 3'b001);
      burst(1'b0, 6, 4, 2'b01, 1'b0, 1'b0, 32'h0, -1, "wrap4");

      // Linear write 1,2,3 at 0x40 with a wait state after beat 2
      burst(1'b1, 16, 3, 2'b00, 1'b0, 1'b0, 32'd1, 1, "lin_w");
      classic_read(16, 3'b000, r);
      check_eq("lin_w_0x40", r, 32'd1);
      classic_read(17, 3'b000, r);
      check_eq("lin_w_0x44", r, 32'd2);
      classic_read(18, 3'b000, r);
      check_eq("lin_w_0x48", r, 32'd3);

      // Reserved cycle type: one-cycle error, no ack, memory untouched
      beat(1'b1, 4, 32'hFFFF_FFFF, 4'hF, 3'b101, 2'b00, r, w, a, e);
      check_eq("err_flag", 32'(e), 32'd1);
      check_eq("err_no_ack", 32'(a), 32'd0);
      check_eq("err_lat", w, 32'd1);
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      @(negedge clk);
      check_eq("err_one_cycle", 32'(wb_err_o), 32'd0);
      check_eq("err_after_ack", 32'(wb_ack_o), 32'd0);
      @(posedge clk);
      #1;
      classic_read(4, 3'b000, r);
      check_eq("err_mem_kept", r, 32'hDEADBEAA);

      // Reset during beat 2 of a linear write burst to 0x80
      classic_write(33, 32'h5A5A_5A5A, 4'hF, 3'b000);
      beat(1'b1, 32, 32'h1111_1111, 4'hF, 3'b010, 2'b00, r, w, a, e);
      check_eq("rstb_b1_ack", 32'(a), 32'd1);
      model_write(32, 32'h1111_1111, 4'hF);
      wb_adr_i = 32'h84;
      wb_dat_i = 32'h2222_2222;
      wb_cti_i = 3'b010;
      wb_rst_i = 1'b1;
      @(posedge clk);
      #1;
      wb_rst_i = 1'b0;
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      @(negedge clk);
      check_eq("rstb_ack", 32'(wb_ack_o), 32'd0);
      check_eq("rstb_err", 32'(wb_err_o), 32'd0);
      check_eq("rstb_dat", wb_dat_o, 32'h0);
      @(posedge clk);
      #1;
      classic_read(32, 3'b000, r);
      check_eq("rstb_0x80", r, 32'h1111_1111);
      classic_read(33, 3'b000, r);
      check_eq("rstb_0x84", r, 32'h5A5A_5A5A);

      // Randomized mix of classic, burst and reserved cycles
      for (int t = 0; t < 80; t++) begin
         int          op, n, st;
         logic [2:0]  ccti;
         op = int'($urandom_range(0, 4));
         case ($urandom_range(0, 2))
            0:       ccti = 3'b000;
            1:       ccti = 3'b001;
            default: ccti = 3'b111;
         endcase
         case (op)
            0: classic_write(int'($urandom_range(0, DEPTH - 1)), $urandom, 4'($urandom), ccti);
            1: classic_read(int'($urandom_range(0, DEPTH - 1)), ccti, r);
            2, 3: begin
               n  = int'($urandom_range(2, 10));
               st = int'($urandom_range(0, n)) - 1;
               burst(op == 3, int'($urandom_range(0, DEPTH - 1)), n, 2'($urandom),
                     1'b1, 1'b1, 32'h0, st, op == 3 ? "rnd_bw" : "rnd_br");
            end
            default: begin
               beat(1'b1, int'($urandom_range(0, DEPTH - 1)), $urandom, 4'hF,
                    3'(3 + $urandom_range(0, 3)), 2'($urandom), r, w, a, e);
               check_eq("rnd_err", 32'(e), 32'd1);
               check_eq("rnd_err_noack", 32'(a), 32'd0);
               bus_idle(1);
            end
         endcase
      end

      // Sweep back over a window to catch stray writes
      for (int i = 0; i < 64; i++) begin
         classic_read(i, 3'b000, r);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
